// File: rtl/gamepad_pkg.sv
// Shared types and constants for the gamepad scanner.
package gamepad_pkg;

   localparam int unsigned ValW = 16;

   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StLatch,
      StClkLo,
      StClkHi,
      StStore,
      StDone
   } state_e;

endpackage

// File: rtl/gamepad_lane.sv
// One pad data line: 2-flop synchroniser, active-low inversion and LSB-first shift register.
module gamepad_lane #(
   parameter int unsigned REG_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 data_i,
   input  logic                 shift_i,
   output logic [REG_WIDTH-1:0] value_o
);

   logic [1:0]           sync_q;
   logic [REG_WIDTH-1:0] sr_q, sr_d;

   // New bit enters at the MSB so the first bit read ends up in bit 0.
   always_comb begin
      sr_d = sr_q;
      if (shift_i) begin
         sr_d = {~sync_q[1], sr_q[REG_WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
         sr_q   <= '0;
      end else begin
         sync_q <= {sync_q[0], data_i};
         sr_q   <= sr_d;
      end
   end

   assign value_o = sr_q;

endmodule

// File: rtl/gamepad_scan.sv
// Multi-group latch/clock gamepad poller with a per-channel value bank and change tracking.
module gamepad_scan
   import gamepad_pkg::*;
#(
   parameter int unsigned DIV        = 150,
   parameter int unsigned SEL_WIDTH  = 1,
   parameter int unsigned DATA_WIDTH = 2,
   parameter int unsigned REG_WIDTH  = 12,
   parameter int unsigned PERIOD     = 0,
   localparam int unsigned SW        = (SEL_WIDTH > 0) ? SEL_WIDTH : 1,
   localparam int unsigned NCH       = DATA_WIDTH * (1 << SEL_WIDTH),
   localparam int unsigned CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [SW-1:0]         gp_sel_o,
   input  logic [DATA_WIDTH-1:0] gp_data_i,
   output logic                  gp_latch_o,
   output logic                  gp_clk_o,
   input  logic                  scan_req_i,
   output logic                  scan_busy_o,
   output logic                  scan_done_o,
   input  logic [CW-1:0]         rd_ch_i,
   output logic [ValW-1:0]       rd_value_o,
   output logic [NCH-1:0]        valid_o,
   output logic [NCH-1:0]        chg_mask_o,
   input  logic [NCH-1:0]        chg_clr_i
);

   localparam int unsigned NG      = 1 << SEL_WIDTH;
   localparam int unsigned TW      = $clog2(DIV);
   localparam int unsigned BW      = $clog2(REG_WIDTH + 1);
   localparam int unsigned PW      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int unsigned PerMax  = (PERIOD > 0) ? PERIOD - 1 : 0;
   localparam logic [SW-1:0] LastGrp = SW'(NG - 1);

   state_e               state_q, state_d;
   logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
   logic [TW-1:0]        idle_cnt_q, idle_cnt_d;
   logic [PW-1:0]        per_cnt_q, per_cnt_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [SW-1:0]        grp_q, grp_d;
   logic                 pend_q, pend_d;
   logic                 latch_q, latch_d;
   logic                 pclk_q, pclk_d;
   logic                 tick, idle_tick, per_inc, expire, start, shift;
   logic [REG_WIDTH-1:0] lane_val [DATA_WIDTH];
   logic [REG_WIDTH-1:0] bank_q [NCH];
   logic [REG_WIDTH-1:0] bank_d [NCH];
   logic [NCH-1:0]       valid_q, valid_d, chg_q, chg_d;

   for (genvar d = 0; d < DATA_WIDTH; d++) begin : g_lane
      gamepad_lane #(
         .REG_WIDTH (REG_WIDTH)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .data_i  (gp_data_i[d]),
         .shift_i (shift),
         .value_o (lane_val[d])
      );
   end

   // Timing: bit tick while active, idle prescaler so the period keeps counting between scans.
   always_comb begin
      tick      = (state_q != StIdle) && (state_q != StStore) && (tick_cnt_q == TW'(DIV - 1));
      idle_tick = (state_q == StIdle) && (idle_cnt_q == TW'(DIV - 1));
      per_inc   = (state_q == StIdle) ? idle_tick : tick;
      expire    = (PERIOD != 0) && per_inc && (per_cnt_q == PW'(PerMax));
      start     = (state_q == StIdle) && (scan_req_i || pend_q || expire);
      shift     = (state_q == StClkLo) && tick;

      tick_cnt_d = tick_cnt_q + TW'(1);
      if ((state_q == StIdle) || (state_q == StStore) || tick) begin
         tick_cnt_d = '0;
      end

      idle_cnt_d = idle_cnt_q;
      if (start) begin
         idle_cnt_d = '0;
      end else if (state_q == StIdle) begin
         idle_cnt_d = idle_tick ? '0 : idle_cnt_q + TW'(1);
      end

      per_cnt_d = per_cnt_q;
      if (PERIOD == 0 || start) begin
         per_cnt_d = '0;
      end else if (per_inc) begin
         per_cnt_d = expire ? '0 : per_cnt_q + PW'(1);
      end

      pend_d = pend_q;
      if (start) begin
         pend_d = 1'b0;
      end else if ((scan_req_i && (state_q != StIdle)) || expire) begin
         pend_d = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      grp_d     = grp_q;
      bit_cnt_d = bit_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StPre;
               grp_d   = '0;
            end
         end
         StPre: begin
            bit_cnt_d = '0;
            if (tick) state_d = StLatch;
         end
         StLatch: if (tick) state_d = StClkLo;
         StClkLo: begin
            if (tick) begin
               bit_cnt_d = bit_cnt_q + BW'(1);
               state_d   = StClkHi;
            end
         end
         StClkHi: begin
            if (tick) state_d = (bit_cnt_q == BW'(REG_WIDTH)) ? StStore : StClkLo;
         end
         StStore: begin
            if (grp_q == LastGrp) begin
               state_d = StDone;
            end else begin
               state_d = StPre;
               grp_d   = grp_q + SW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      latch_d     = (state_q == StLatch);
      pclk_d      = (state_q == StClkHi);
      scan_busy_o = (state_q != StIdle);
      scan_done_o = (state_q == StDone);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         tick_cnt_q <= '0;
         idle_cnt_q <= '0;
         per_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         grp_q      <= '0;
         pend_q     <= 1'b0;
         latch_q    <= 1'b0;
         pclk_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         per_cnt_q  <= per_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         grp_q      <= grp_d;
         pend_q     <= pend_d;
         latch_q    <= latch_d;
         pclk_q     <= pclk_d;
      end
   end

   // Set beats a simultaneous write-one-to-clear.
   always_comb begin
      valid_d = valid_q;
      chg_d   = chg_q & ~chg_clr_i;
      for (int unsigned c = 0; c < NCH; c++) begin
         bank_d[c] = bank_q[c];
         if ((state_q == StStore) && (grp_q == SW'(c / DATA_WIDTH))) begin
            bank_d[c]  = lane_val[c % DATA_WIDTH];
            valid_d[c] = 1'b1;
            if (!valid_q[c] || (lane_val[c % DATA_WIDTH] != bank_q[c])) begin
               chg_d[c] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < NCH; c++) begin
            bank_q[c] <= '0;
         end
         valid_q <= '0;
         chg_q   <= '0;
      end else begin
         for (int unsigned c = 0; c < NCH; c++) begin
            bank_q[c] <= bank_d[c];
         end
         valid_q <= valid_d;
         chg_q   <= chg_d;
      end
   end

   always_comb begin
      rd_value_o = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         if (rd_ch_i == CW'(c)) rd_value_o = ValW'(bank_q[c]);
      end
   end

   assign gp_sel_o   = grp_q;
   assign gp_latch_o = latch_q;
   assign gp_clk_o   = pclk_q;
   assign valid_o    = valid_q;
   assign chg_mask_o = chg_q;

endmodule

// File: tb/tb_gamepad_scan.sv
// Directed bench: two-group scanner with pad models, plus a periodic 3-lane instance.
module tb_gamepad_scan;

   logic        clk = 1'b0;
   logic        rst_n, rst_pn;
   logic [0:0]  gp_sel, gp_sel_p;
   logic [1:0]  gp_data;
   logic [2:0]  gp_data_p;
   logic        gp_latch, gp_clk, gp_latch_p, gp_clk_p;
   logic        scan_req, scan_req_p, scan_busy, scan_done, busy_p, done_p;
   logic [1:0]  rd_ch;
   logic [2:0]  rd_ch_p;
   logic [15:0] rd_value, rd_value_p;
   logic [3:0]  valid, chg_mask, chg_clr;
   logic [5:0]  valid_p, chg_p, chg_clr_p;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   gamepad_scan #(
      .DIV (4), .SEL_WIDTH (1), .DATA_WIDTH (2), .REG_WIDTH (12), .PERIOD (0)
   ) dut (
      .clk (clk), .rst_n (rst_n), .gp_sel_o (gp_sel), .gp_data_i (gp_data),
      .gp_latch_o (gp_latch), .gp_clk_o (gp_clk), .scan_req_i (scan_req),
      .scan_busy_o (scan_busy), .scan_done_o (scan_done), .rd_ch_i (rd_ch),
      .rd_value_o (rd_value), .valid_o (valid), .chg_mask_o (chg_mask), .chg_clr_i (chg_clr)
   );

   gamepad_scan #(
      .DIV (4), .SEL_WIDTH (1), .DATA_WIDTH (3), .REG_WIDTH (12), .PERIOD (300)
   ) dut_p (
      .clk (clk), .rst_n (rst_pn), .gp_sel_o (gp_sel_p), .gp_data_i (gp_data_p),
      .gp_latch_o (gp_latch_p), .gp_clk_o (gp_clk_p), .scan_req_i (scan_req_p),
      .scan_busy_o (busy_p), .scan_done_o (done_p), .rd_ch_i (rd_ch_p),
      .rd_value_o (rd_value_p), .valid_o (valid_p), .chg_mask_o (chg_p), .chg_clr_i (chg_clr_p)
   );

   // Pad model: channel = group*2 + lane; line is active-low, bit 0 shifted out first.
   logic [11:0] pad_val [4];
   logic [11:0] sr [4];
   logic        gp_clk_prev = 1'b0;

   always @(posedge clk) begin
      gp_clk_prev <= gp_clk;
      for (int c = 0; c < 4; c++) begin
         if (gp_latch) sr[c] <= pad_val[c];
         else if (gp_clk && !gp_clk_prev) sr[c] <= {1'b0, sr[c][11:1]};
      end
   end

   assign gp_data   = {~sr[{gp_sel, 1'b1}][0], ~sr[{gp_sel, 1'b0}][0]};
   assign gp_data_p = 3'b000;

   int cyc = 0, done_cnt = 0, starts_a = 0, p_idx = 0, lat_run = 0, lat_w = 0;
   int t_p [4];
   logic busy_prev = 1'b0, busy_p_prev = 1'b0;

   always @(negedge clk) begin
      cyc         <= cyc + 1;
      busy_prev   <= scan_busy;
      busy_p_prev <= busy_p;
      if (scan_done) done_cnt <= done_cnt + 1;
      if (scan_busy && !busy_prev) starts_a <= starts_a + 1;
      if (busy_p && !busy_p_prev && p_idx < 4) begin
         t_p[p_idx] <= cyc;
         p_idx      <= p_idx + 1;
      end
      if (gp_latch_p) lat_run <= lat_run + 1;
      else if (lat_run != 0) begin
         lat_w   <= lat_run;
         lat_run <= 0;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns at the negedge following the edge that samples the request.
   task automatic start_scan();
      @(negedge clk) scan_req = 1'b1;
      @(negedge clk) scan_req = 1'b0;
   endtask

   task automatic wait_done(input int n0, output int n);
      n = n0;
      while (!scan_done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_eq("done_seen", scan_done, 1);
   endtask

   task automatic check_bank(input string tag, input int c, input logic [15:0] exp);
      rd_ch = 2'(c);
      #1 check_eq(tag, rd_value, exp);
   endtask

   int n, base;

   initial begin
      rst_n = 0; rst_pn = 0; scan_req = 0; scan_req_p = 0;
      chg_clr = '0; chg_clr_p = '0; rd_ch = '0; rd_ch_p = '0;
      pad_val[0] = 12'h0A5; pad_val[1] = 12'h3FF; pad_val[2] = 12'h001; pad_val[3] = 12'h800;
      repeat (3) @(negedge clk);
      rst_n = 1; rst_pn = 1;
      @(negedge clk);

      check_eq("rst_busy", scan_busy, 0);
      check_eq("rst_done", scan_done, 0);
      check_eq("rst_latch", gp_latch, 0);
      check_eq("rst_gpclk", gp_clk, 0);
      check_eq("rst_sel", gp_sel, 0);
      check_eq("rst_valid", valid, 0);
      check_eq("rst_chg", chg_mask, 0);
      check_bank("rst_rd0", 0, 16'h0);

      // Full scan: 2 groups of (2+24)*4+1 cycles plus DONE, counted from the request edge.
      start_scan();
      wait_done(1, n);
      check_eq("scan_len", n, 211);
      @(negedge clk);
      check_eq("done_pulse", scan_done, 0);
      check_eq("idle_after", scan_busy, 0);
      check_bank("bank0", 0, 16'h00A5);
      check_bank("bank1", 1, 16'h03FF);
      check_bank("bank2", 2, 16'h0001);
      check_bank("bank3", 3, 16'h0800);
      check_eq("valid_all", valid, 4'hF);
      check_eq("chg_all", chg_mask, 4'hF);

      @(negedge clk) chg_clr = 4'hF;
      @(negedge clk) chg_clr = 4'h0;
      check_eq("chg_cleared", chg_mask, 4'h0);
      pad_val[2] = 12'h002;
      start_scan();
      wait_done(1, n);
      check_eq("chg_ch2", chg_mask, 4'b0100);
      check_bank("bank2_new", 2, 16'h0002);

      // Three requests during a scan coalesce into one follow-up scan.
      @(negedge clk);
      base = done_cnt;
      start_scan();
      repeat (20) @(negedge clk);
      start_scan();
      repeat (30) @(negedge clk);
      start_scan();
      repeat (50) @(negedge clk);
      start_scan();
      repeat (700) @(negedge clk);
      check_eq("coalesce", done_cnt - base, 2);
      check_eq("coalesce_idle", scan_busy, 0);

      // Clear of ch0 lands in the group-0 STORE cycle (index 104) where ch0 changes.
      @(negedge clk) chg_clr = 4'hF;
      @(negedge clk) chg_clr = 4'h0;
      pad_val[0] = 12'h0A6;
      start_scan();
      repeat (104) @(negedge clk);
      chg_clr = 4'b0001;
      @(negedge clk) chg_clr = 4'h0;
      wait_done(106, n);
      check_eq("set_wins", chg_mask, 4'b0001);
      check_bank("bank0_new", 0, 16'h00A6);

      // Reset while in the first CLK_LO of group 1 (index 114).
      @(negedge clk);
      start_scan();
      repeat (114) @(negedge clk);
      check_eq("mid_sel", gp_sel, 1);
      check_eq("mid_busy", scan_busy, 1);
      #1 rst_n = 0;
      #1;
      check_eq("ar_busy", scan_busy, 0);
      check_eq("ar_sel", gp_sel, 0);
      check_eq("ar_latch", gp_latch, 0);
      check_eq("ar_gpclk", gp_clk, 0);
      check_eq("ar_done", scan_done, 0);
      check_eq("ar_valid", valid, 0);
      check_eq("ar_chg", chg_mask, 0);
      check_bank("ar_bank2", 2, 16'h0);
      check_bank("ar_bank3", 3, 16'h0);
      @(negedge clk) rst_n = 1;
      base = starts_a;
      repeat (300) @(negedge clk);
      check_eq("no_restart", starts_a - base, 0);
      check_eq("post_idle", scan_busy, 0);

      // Periodic instance: 300 period units = 52 scan ticks + 248 idle ticks, plus the
      // two STORE and one DONE cycles that advance nothing: 1203 cycles start to start.
      n = 0;
      while (p_idx < 3 && n < 8000) begin
         @(negedge clk);
         n++;
      end
      check_eq("per_starts", p_idx >= 3, 1);
      check_eq("per_gap1", t_p[1] - t_p[0], 1203);
      check_eq("per_gap2", t_p[2] - t_p[1], 1203);
      check_eq("latch_w", lat_w, 4);
      check_eq("per_valid", valid_p, 6'h3F);
      check_eq("per_chg", chg_p, 6'h3F);
      rd_ch_p = 3'd5;
      #1 check_eq("per_rd5", rd_value_p, 16'h0FFF);
      rd_ch_p = 3'd6;
      #1 check_eq("per_rd6", rd_value_p, 16'h0);
      rd_ch_p = 3'd7;
      #1 check_eq("per_rd7", rd_value_p, 16'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
